// File: rtl/sb_packet_deframing.sv
`default_nettype none
// ============================================================================
//  Module   : sb_packet_deframing
//  Purpose  : Receive-side sideband packet deframer. Rebuilds header-only or
//             header+data messages from 64-bit deserialized phases, checks the
//             control (CP) and data (DP) parity bits, and presents each message
//             as a one-cycle registered strobe. A watchdog drops a frame whose
//             data phase never arrives.
//
//  Ports    : i_clk          clock
//             i_rst_n        asynchronous active-low reset
//             i_phase        64-bit deserialized phase ([63] DP, [62] CP, [61:0] header)
//             i_phase_valid  one-cycle strobe qualifying i_phase
//             o_rx_header    received header (bits [61:0] of the header phase)
//             o_rx_data      received data, 0 for single-phase messages
//             o_has_data     message carried a data phase
//             o_msg_valid    one-cycle strobe, outputs hold a complete message
//             o_cp_err       CP mismatch for the delivered message
//             o_dp_err       DP mismatch for the delivered message
//             o_frame_err    one-cycle strobe, data phase missing, frame dropped
//             o_busy         high while waiting for a data phase
//
//  Revision : 1.0  initial release
// ============================================================================
module sb_packet_deframing #(
    parameter logic [4:0] OPC_W_DATA   = 5'b11011,
    parameter int         DATA_TIMEOUT = 16,
    parameter int         TMR_W        = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [63:0]  i_phase,
    input  logic         i_phase_valid,
    output logic [61:0]  o_rx_header,
    output logic [63:0]  o_rx_data,
    output logic         o_has_data,
    output logic         o_msg_valid,
    output logic         o_cp_err,
    output logic         o_dp_err,
    output logic         o_frame_err,
    output logic         o_busy
);

    localparam logic [TMR_W-1:0] C_TIMEOUT = TMR_W'(DATA_TIMEOUT);
    localparam logic [TMR_W-1:0] C_TMR_ONE = TMR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Header-phase latches held while waiting for the data phase
    logic [61:0]        r_hdr;
    logic               r_hdr_cp_err;
    logic               r_hdr_dp;
    logic [TMR_W-1:0]   r_timer;

    // Registered message outputs
    logic [61:0]        r_rx_header;
    logic [63:0]        r_rx_data;
    logic               r_has_data;
    logic               r_msg_valid;
    logic               r_cp_err;
    logic               r_dp_err;
    logic               r_frame_err;

    // Phase decode
    logic               w_is_two_phase;
    logic               w_phase_cp_err;
    logic               w_data_parity;

    // FSM actions
    logic               w_deliver;
    logic               w_deliver_two;
    logic               w_latch_hdr;
    logic               w_timeout;

    assign w_is_two_phase = (i_phase[4:0] == OPC_W_DATA);
    assign w_phase_cp_err = i_phase[62] ^ (^i_phase[61:0]);
    assign w_data_parity  = ^i_phase;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and action decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_deliver     = 1'b0;
        w_deliver_two = 1'b0;
        w_latch_hdr   = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_phase_valid) begin
                    if (w_is_two_phase) begin
                        w_latch_hdr = 1'b1;
                        w_state_nxt = ST_WAIT_DATA;
                    end else begin
                        w_deliver   = 1'b1;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // A data phase on the timeout cycle still wins
                if (i_phase_valid) begin
                    w_deliver     = 1'b1;
                    w_deliver_two = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_timer == C_TIMEOUT) begin
                    w_timeout     = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Header latch and watchdog timer
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hdr        <= '0;
            r_hdr_cp_err <= 1'b0;
            r_hdr_dp     <= 1'b0;
            r_timer      <= '0;
        end else if (w_latch_hdr) begin
            r_hdr        <= i_phase[61:0];
            r_hdr_cp_err <= w_phase_cp_err;
            r_hdr_dp     <= i_phase[63];
            r_timer      <= '0;
        end else if (r_state == ST_WAIT_DATA && !i_phase_valid && !w_timeout) begin
            r_timer      <= r_timer + C_TMR_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Message output registers; contents hold until the next delivery
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_header <= '0;
            r_rx_data   <= '0;
            r_has_data  <= 1'b0;
            r_cp_err    <= 1'b0;
            r_dp_err    <= 1'b0;
            r_msg_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_msg_valid <= w_deliver;
            r_frame_err <= w_timeout;
            if (w_deliver) begin
                if (w_deliver_two) begin
                    r_rx_header <= r_hdr;
                    r_rx_data   <= i_phase;
                    r_has_data  <= 1'b1;
                    r_cp_err    <= r_hdr_cp_err;
                    r_dp_err    <= r_hdr_dp ^ w_data_parity;
                end else begin
                    r_rx_header <= i_phase[61:0];
                    r_rx_data   <= '0;
                    r_has_data  <= 1'b0;
                    r_cp_err    <= w_phase_cp_err;
                    // Single-phase messages must carry DP = 0
                    r_dp_err    <= i_phase[63];
                end
            end
        end
    end

    assign o_rx_header = r_rx_header;
    assign o_rx_data   = r_rx_data;
    assign o_has_data  = r_has_data;
    assign o_msg_valid = r_msg_valid;
    assign o_cp_err    = r_cp_err;
    assign o_dp_err    = r_dp_err;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state == ST_WAIT_DATA);

endmodule
`default_nettype wire

// File: tb/tb_sb_packet_deframing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sb_packet_deframing
//  Purpose  : Scoreboard testbench for sb_packet_deframing. Stimulus pushes
//             expected messages / frame errors (tagged with the cycle they
//             must appear in) into a queue; a monitor pops and compares on
//             every output strobe.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sb_packet_deframing;

    localparam logic [4:0] OPC2 = 5'b11011;
    localparam logic [4:0] OPC1 = 5'b10010;
    localparam int         TO   = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [63:0]  i_phase;
    logic         i_phase_valid;
    logic [61:0]  o_rx_header;
    logic [63:0]  o_rx_data;
    logic         o_has_data;
    logic         o_msg_valid;
    logic         o_cp_err;
    logic         o_dp_err;
    logic         o_frame_err;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    sb_packet_deframing #(
        .OPC_W_DATA   (OPC2),
        .DATA_TIMEOUT (TO),
        .TMR_W        (5)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_phase       (i_phase),
        .i_phase_valid (i_phase_valid),
        .o_rx_header   (o_rx_header),
        .o_rx_data     (o_rx_data),
        .o_has_data    (o_has_data),
        .o_msg_valid   (o_msg_valid),
        .o_cp_err      (o_cp_err),
        .o_dp_err      (o_dp_err),
        .o_frame_err   (o_frame_err),
        .o_busy        (o_busy)
    );

    typedef struct {
        int          tag;
        bit          is_err;
        logic [61:0] hdr;
        logic [63:0] data;
        bit          has;
        bit          cp;
        bit          dp;
    } exp_t;

    exp_t        q[$];
    bit          exp_busy[int];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model: a pending two-phase header and the cycle it was taken
    bit          m_pending;
    int          m_hdr_n;
    logic [63:0] m_hdr_phase;
    logic [61:0] m_last_hdr;
    logic [63:0] m_last_data;
    bit          m_last_has;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input bit cp_ok, input bit dp);
        logic [61:0] h;
        logic        cp;
        h      = {$urandom, $urandom};
        h[4:0] = opc;
        cp     = (^h) ^ !cp_ok;
        return {dp, cp, h};
    endfunction

    // Model one sampling edge n with input (v, p)
    task automatic model(input logic v, input logic [63:0] p, input int n);
        exp_t e;
        e.tag = n;
        if (m_pending && v) begin
            e.is_err = 1'b0;
            e.hdr    = m_hdr_phase[61:0];
            e.data   = p;
            e.has    = 1'b1;
            e.cp     = m_hdr_phase[62] != ^m_hdr_phase[61:0];
            e.dp     = m_hdr_phase[63] != ^p;
            q.push_back(e);
            m_pending = 1'b0;
        end else if (m_pending && n == m_hdr_n + TO + 1) begin
            e.is_err = 1'b1;
            e.hdr    = m_last_hdr;
            e.data   = m_last_data;
            e.has    = m_last_has;
            e.cp     = 1'b0;
            e.dp     = 1'b0;
            q.push_back(e);
            m_pending = 1'b0;
        end else if (!m_pending && v) begin
            if (p[4:0] == OPC2) begin
                m_pending   = 1'b1;
                m_hdr_n     = n;
                m_hdr_phase = p;
            end else begin
                e.is_err = 1'b0;
                e.hdr    = p[61:0];
                e.data   = 64'h0;
                e.has    = 1'b0;
                e.cp     = p[62] != ^p[61:0];
                e.dp     = p[63];
                q.push_back(e);
            end
        end
        if (!e.is_err && (e.tag == n) && q.size() > 0 && q[$].tag == n) begin
            m_last_hdr  = q[$].hdr;
            m_last_data = q[$].data;
            m_last_has  = q[$].has;
        end
        exp_busy[n] = m_pending;
    endtask

    task automatic step(input logic v, input logic [63:0] p);
        @(negedge i_clk);
        i_phase_valid = v;
        i_phase       = p;
        model(v, p, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 64'h0);
    endtask

    task automatic model_reset();
        q.delete();
        exp_busy.delete();
        m_pending   = 1'b0;
        m_last_hdr  = '0;
        m_last_data = '0;
        m_last_has  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_header"}, 64'(o_rx_header), 64'h0);
        chk({tag, "_rx_data"},   o_rx_data,   64'h0);
        chk({tag, "_has_data"},  64'(o_has_data),  64'h0);
        chk({tag, "_msg_valid"}, 64'(o_msg_valid), 64'h0);
        chk({tag, "_cp_err"},    64'(o_cp_err),    64'h0);
        chk({tag, "_dp_err"},    64'(o_dp_err),    64'h0);
        chk({tag, "_frame_err"}, 64'(o_frame_err), 64'h0);
        chk({tag, "_busy"},      64'(o_busy),      64'h0);
    endtask

    // ------------------------------------------------------------------------
    // Monitor: samples 1 ns after each rising edge
    // ------------------------------------------------------------------------
    exp_t me;
    always @(posedge i_clk) begin
        cyc = cyc + 1;
        #1;
        if (i_rst_n) begin
            if (o_msg_valid || o_frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 64'({o_msg_valid, o_frame_err}), 64'h0);
                end else begin
                    me = q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(me.tag));
                    chk("msg_valid", 64'(o_msg_valid), 64'(!me.is_err));
                    chk("frame_err", 64'(o_frame_err), 64'(me.is_err));
                    chk("rx_header", 64'(o_rx_header), 64'(me.hdr));
                    chk("rx_data",   o_rx_data, me.data);
                    chk("has_data",  64'(o_has_data), 64'(me.has));
                    if (!me.is_err) begin
                        chk("cp_err", 64'(o_cp_err), 64'(me.cp));
                        chk("dp_err", 64'(o_dp_err), 64'(me.dp));
                    end
                end
            end
            while (q.size() > 0 && q[0].tag <= cyc) begin
                me = q.pop_front();
                chk("missing_strobe", 64'({o_msg_valid, o_frame_err}),
                    me.is_err ? 64'h1 : 64'h2);
            end
            if (exp_busy.exists(cyc)) begin
                chk("busy", 64'(o_busy), 64'(exp_busy[cyc]));
                exp_busy.delete(cyc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int          pv;
    bit          rv;
    logic [63:0] rp;
    logic [4:0]  ropc;

    initial begin
        i_rst_n       = 1'b0;
        i_phase_valid = 1'b0;
        i_phase       = 64'h0;
        model_reset();
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst_n = 1'b1;

        // Single-phase, clean
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b0));
        idle(2);
        // Two-phase, data 1 three cycles after the header, DP = ^1 = 1
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b1));
        idle(2);
        step(1'b1, 64'h1);
        idle(2);
        // CP error on single-phase
        step(1'b1, mk_hdr(OPC1, 1'b0, 1'b0));
        idle(1);
        // DP error: DP = 0 with data 1
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b0));
        idle(1);
        step(1'b1, 64'h1);
        idle(1);
        // DP set on a single-phase message
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b1));
        idle(1);
        // Timeout, then a normal single-phase header
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b0));
        idle(20);
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b0));
        idle(2);
        // Back-to-back: single, header, data, single
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b0));
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b0));
        step(1'b1, {$urandom, $urandom});
        step(1'b1, mk_hdr(5'b00001, 1'b1, 1'b0));
        idle(2);
        // Data exactly on the timeout cycle
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b1));
        idle(TO);
        step(1'b1, {$urandom, $urandom});
        idle(2);
        // Timeout immediately followed by a header on the next cycle
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b0));
        idle(TO + 1);
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b0));
        idle(2);

        // Reset in the middle of a frame
        step(1'b1, mk_hdr(OPC2, 1'b1, 1'b0));
        step(1'b0, 64'h0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, mk_hdr(OPC1, 1'b1, 1'b0));
        idle(2);

        // Randomized traffic with varying phase density
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0:       pv = 90;
                1:       pv = 40;
                default: pv = 4;
            endcase
            rv = ($urandom_range(99) < pv);
            if (m_pending) begin
                rp = {$urandom, $urandom};
            end else begin
                ropc = ($urandom_range(2) == 0) ? OPC2 : 5'($urandom);
                rp   = mk_hdr(ropc, $urandom_range(7) != 0,
                              (ropc == OPC2) ? 1'($urandom) : ($urandom_range(7) == 0));
            end
            step(rv, rp);
        end

        idle(TO + 8);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_packet_deframing.md
Name: sb_packet_deframing

Overview:
- Receive-side counterpart of the sideband packet framer.
- Takes 64-bit phases from the sideband deserializer and rebuilds each packet: one header phase, plus an optional data phase.
- Checks the control parity (CP) and data parity (DP) bits, then presents the header and data as one registered message to the sideband message decoder.
- Guards against a missing data phase with a watchdog.

Parameters:
- OPC_W_DATA, 5'b11011: opcode in header bits [4:0] that marks a message followed by a 64-bit data phase. All other opcodes are single-phase.
- DATA_TIMEOUT, 16: cycles allowed in WAIT_DATA, from entry until the data phase arrives, before the frame is aborted.
- TMR_W, 5: timer width, with 2^TMR_W > DATA_TIMEOUT.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_phase  in  64  deserialized phase
- i_phase_valid  in  1  one-cycle strobe; i_phase is valid this cycle
- o_rx_header  out  62  received header, bits [61:0] of the header phase
- o_rx_data  out  64  received data; 0 for single-phase messages
- o_has_data  out  1  message carried a data phase
- o_msg_valid  out  1  one-cycle strobe; outputs hold a complete message
- o_cp_err  out  1  CP mismatch for the delivered message (qualified by o_msg_valid)
- o_dp_err  out  1  DP mismatch for the delivered message (qualified by o_msg_valid)
- o_frame_err  out  1  one-cycle strobe; data phase missing, frame dropped
- o_busy  out  1  high while in WAIT_DATA

Behaviour:
- Reset values: all outputs 0, state IDLE, timer 0, internal header/parity latches 0. Asynchronous reset clears everything immediately, including mid-frame. Any partial frame is discarded and no strobe is issued.
- Header phase layout, matching the framer: [63] DP, [62] CP, [61:0] header.
- Parity rules:
  - CP error when CP != ^header[61:0].
  - For a two-phase message, DP error when DP != ^data[63:0].
  - For a single-phase message, DP must be 0; any 1 is a DP error.
- State IDLE:
  - i_phase_valid with header[4:0] != OPC_W_DATA:
    - Next cycle: o_rx_header = header, o_rx_data = 0, o_has_data = 0, parity flags set per the rules above, o_msg_valid = 1 for one cycle.
    - Latency: 1 cycle. State stays IDLE.
  - i_phase_valid with header[4:0] == OPC_W_DATA:
    - Latch header, CP result and received DP bit.
    - Next state WAIT_DATA, timer cleared to 0. No output strobe.
- State WAIT_DATA:
  - o_busy = 1. The timer increments every cycle without i_phase_valid.
  - i_phase_valid: the phase is data. Next cycle:
    - o_rx_header = latched header, o_rx_data = i_phase, o_has_data = 1.
    - o_cp_err = latched CP result; o_dp_err = (latched DP != ^i_phase).
    - o_msg_valid = 1 for one cycle; return to IDLE.
    - Latency from the data phase: 1 cycle.
  - Timer reaches DATA_TIMEOUT with no phase:
    - Next cycle o_frame_err = 1 for one cycle; return to IDLE.
    - o_rx_* unchanged, no o_msg_valid.
  - Simultaneous timeout and i_phase_valid on the same cycle: the phase wins, the message is delivered and there is no frame error.
- o_rx_header, o_rx_data, o_has_data and the parity flags hold their values until the next o_msg_valid.
- No backpressure; a phase can arrive every cycle.
  - Back-to-back: a header phase in the cycle right after a delivery is accepted normally.
  - A header phase arriving in the same cycle the FSM returns to IDLE is handled as an IDLE header.
- Parity errors do not change sequencing. The message is still delivered, with the flag set. The opcode is used as received even when CP is bad.
- o_msg_valid and o_frame_err are never high together.

Test Plan:
- Single-phase message: header opcode 5'b10010, CP correct, DP=0, one strobe -> next cycle o_msg_valid=1, o_has_data=0, o_rx_data=0, o_cp_err=0, o_dp_err=0, header matches.
- Two-phase message: header opcode 5'b11011 with correct CP/DP, data 64'h0000_0000_0000_0001 three cycles later -> o_busy=1 for those cycles; one cycle after the data, o_msg_valid=1, o_has_data=1, o_rx_data=64'h1, no errors.
- CP error: single-phase header with bit 62 inverted -> o_msg_valid=1, o_cp_err=1, o_dp_err=0. Then DP error: two-phase message with DP=0 but data 64'h1 -> o_dp_err=1, o_cp_err=0.
- Timeout: opcode 5'b11011 header, then no phase for DATA_TIMEOUT=16 cycles -> one cycle o_frame_err=1, no o_msg_valid, o_busy low afterwards. A following single-phase header is delivered normally.
- Back-to-back: four phases on consecutive cycles (single, two-phase header+data, single) -> three o_msg_valid pulses with correct contents. Boundary: a data phase arriving on exactly the timeout cycle is delivered with o_frame_err=0.
- Reset mid-frame: assert i_rst_n=0 while in WAIT_DATA -> all outputs 0 immediately. After release, a new single-phase header is delivered with 1-cycle latency.
